// File: rtl/hls_runseq_pkg.sv
// Shared types and constants for the multi-run accelerator sequencer.
// Status codes are ordered so that a larger code always outranks a smaller one.
package hls_runseq_pkg;

   typedef enum logic [1:0] {
      K_WRITE = 2'd0,
      K_START = 2'd1,
      K_CHECK = 2'd2,
      K_END   = 2'd3
   } vec_kind_t;

   typedef enum logic [1:0] {
      ST_PASS    = 2'd0,
      ST_FAIL    = 2'd1,
      ST_TIMEOUT = 2'd2,
      ST_PROTO   = 2'd3
   } res_status_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DRST,
      S_LOAD,
      S_WR_WAIT,
      S_GO,
      S_WAIT,
      S_CHK,
      S_RD_WAIT,
      S_DRAIN,
      S_REPORT
   } state_t;

   localparam int ACC_TIMEOUT = 16;

   // Sticky status update: the more severe code wins.
   function automatic res_status_t merge_status(input res_status_t cur, input res_status_t evt);
      return (evt > cur) ? evt : cur;
   endfunction

endpackage

// File: rtl/hls_runseq_cmp.sv
// Read-back comparator: bitwise equality, or float ULP distance when
// HLS_RUNSEQ_ULP_EN is defined (DATA_W of 32 or 64).
module hls_runseq_cmp #(
   parameter int DATA_W  = 32,
   parameter int MAX_ULP = 0
) (
   input  logic [DATA_W-1:0] actual,
   input  logic [DATA_W-1:0] expected,
   output logic              match
);

   logic [DATA_W-1:0] bit_diff;

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_diff
      assign bit_diff[gi] = actual[gi] ^ expected[gi];
   end

`ifdef HLS_RUNSEQ_ULP_EN
   localparam int EXP_W = (DATA_W == 64) ? 11 : 8;
   localparam int MAN_W = DATA_W - 1 - EXP_W;

   logic                act_nan;
   logic                exp_nan;
   logic signed [DATA_W:0] act_key;
   logic signed [DATA_W:0] exp_key;
   logic signed [DATA_W:0] dist;
   logic        [DATA_W:0] dist_abs;

   // Sign-magnitude mapped onto a signed line; +0 and -0 both land on 0.
   always_comb begin
      act_nan  = (&actual[DATA_W-2 -: EXP_W]) && (|actual[MAN_W-1:0]);
      exp_nan  = (&expected[DATA_W-2 -: EXP_W]) && (|expected[MAN_W-1:0]);
      act_key  = actual[DATA_W-1] ? -$signed({2'b00, actual[DATA_W-2:0]})
                                  :  $signed({2'b00, actual[DATA_W-2:0]});
      exp_key  = expected[DATA_W-1] ? -$signed({2'b00, expected[DATA_W-2:0]})
                                    :  $signed({2'b00, expected[DATA_W-2:0]});
      dist     = act_key - exp_key;
      dist_abs = (dist < 0) ? $unsigned(-dist) : $unsigned(dist);
      if (act_nan || exp_nan) begin
         match = ~|bit_diff;
      end else begin
         match = (dist_abs <= (DATA_W+1)'(MAX_ULP));
      end
   end
`else
   logic [31:0] max_ulp_unused;
   assign max_ulp_unused = 32'(MAX_ULP);
   assign match = ~|bit_diff;
`endif

endmodule

// File: rtl/hls_run_sequencer.sv
// Multi-run harness for a Bambu accelerator: preload, start, time, read back, report.
// Optional float ULP comparison enabled by defining HLS_RUNSEQ_ULP_EN.
module hls_run_sequencer
   import hls_runseq_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int CYC_W      = 32,
   parameter int TIMEOUT    = 200000000,
   parameter int RST_CYCLES = 2,
   parameter int MAX_ULP    = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              vec_valid,
   output logic              vec_ready,
   input  logic [1:0]        vec_kind,
   input  logic [ADDR_W-1:0] vec_addr,
   input  logic [DATA_W-1:0] vec_data,
   output logic              dut_reset_n,
   output logic              dut_start_port,
   input  logic              dut_done_port,
   output logic              S_oe_ram,
   output logic              S_we_ram,
   output logic [ADDR_W-1:0] S_addr_ram,
   output logic [DATA_W-1:0] S_Wdata_ram,
   output logic [5:0]        S_data_ram_size,
   input  logic [DATA_W-1:0] Sout_Rdata_ram,
   input  logic              Sout_DataRdy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [1:0]        res_status,
   output logic [CYC_W-1:0]  res_cycles,
   output logic [15:0]       res_run_idx,
   output logic [15:0]       res_checked,
   output logic              busy
);

   localparam logic [CYC_W-1:0] TIMEOUT_CYC = CYC_W'(TIMEOUT);
   localparam logic [CYC_W-1:0] DRST_LAST   = CYC_W'(RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] ACC_LAST    = CYC_W'(ACC_TIMEOUT - 1);

   state_t            state_reg;
   res_status_t       status_reg;
   logic [CYC_W-1:0]  cyc_reg;
   logic [CYC_W-1:0]  aux_cnt_reg;
   logic [15:0]       run_idx_reg;
   logic [15:0]       checked_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] exp_reg;
   logic              vec_ready_reg;
   logic              dut_reset_n_reg;
   logic              start_reg;
   logic              oe_reg;
   logic              we_reg;
   logic              res_valid_reg;
   logic              busy_reg;

   vec_kind_t         kind;
   logic              accept;
   logic              rd_match;

   assign kind   = vec_kind_t'(vec_kind);
   assign accept = vec_valid && vec_ready_reg;

   hls_runseq_cmp #(
      .DATA_W  (DATA_W),
      .MAX_ULP (MAX_ULP)
   ) u_cmp (
      .actual   (Sout_Rdata_ram),
      .expected (exp_reg),
      .match    (rd_match)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         status_reg      <= ST_PASS;
         cyc_reg         <= '0;
         aux_cnt_reg     <= '0;
         run_idx_reg     <= '0;
         checked_reg     <= '0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         exp_reg         <= '0;
         vec_ready_reg   <= 1'b0;
         dut_reset_n_reg <= 1'b0;
         start_reg       <= 1'b0;
         oe_reg          <= 1'b0;
         we_reg          <= 1'b0;
         res_valid_reg   <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         start_reg <= 1'b0;
         we_reg    <= 1'b0;
         oe_reg    <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               dut_reset_n_reg <= 1'b1;
               if (vec_valid) begin
                  state_reg       <= S_DRST;
                  dut_reset_n_reg <= 1'b0;
                  busy_reg        <= 1'b1;
                  aux_cnt_reg     <= '0;
               end
            end
            S_DRST: begin
               aux_cnt_reg <= aux_cnt_reg + 1'b1;
               if (aux_cnt_reg == DRST_LAST) begin
                  state_reg       <= S_LOAD;
                  dut_reset_n_reg <= 1'b1;
                  vec_ready_reg   <= 1'b1;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  vec_ready_reg <= 1'b0;
                  case (kind)
                     K_WRITE: begin
                        state_reg   <= S_WR_WAIT;
                        we_reg      <= 1'b1;
                        addr_reg    <= vec_addr;
                        wdata_reg   <= vec_data;
                        aux_cnt_reg <= '0;
                     end
                     K_START: begin
                        state_reg <= S_GO;
                        start_reg <= 1'b1;
                     end
                     K_CHECK: begin
                        state_reg     <= S_DRAIN;
                        vec_ready_reg <= 1'b1;
                        status_reg    <= ST_PROTO;
                     end
                     default: begin
                        // A premature END is itself the terminator, so nothing is left to drain.
                        state_reg     <= S_REPORT;
                        res_valid_reg <= 1'b1;
                        status_reg    <= ST_PROTO;
                     end
                  endcase
               end
            end
            S_WR_WAIT: begin
               aux_cnt_reg <= aux_cnt_reg + 1'b1;
               if (Sout_DataRdy) begin
                  state_reg     <= S_LOAD;
                  vec_ready_reg <= 1'b1;
               end else if (aux_cnt_reg == ACC_LAST) begin
                  state_reg     <= S_LOAD;
                  vec_ready_reg <= 1'b1;
                  status_reg    <= merge_status(status_reg, ST_FAIL);
               end
            end
            S_GO: begin
               state_reg <= S_WAIT;
               cyc_reg   <= CYC_W'(1);
            end
            S_WAIT: begin
               if (dut_done_port) begin
                  state_reg     <= S_CHK;
                  vec_ready_reg <= 1'b1;
                  cyc_reg       <= (cyc_reg >= TIMEOUT_CYC) ? TIMEOUT_CYC : cyc_reg + 1'b1;
               end else if (cyc_reg >= TIMEOUT_CYC) begin
                  state_reg     <= S_DRAIN;
                  vec_ready_reg <= 1'b1;
                  status_reg    <= merge_status(status_reg, ST_TIMEOUT);
               end else begin
                  cyc_reg <= cyc_reg + 1'b1;
               end
            end
            S_CHK: begin
               if (accept) begin
                  vec_ready_reg <= 1'b0;
                  case (kind)
                     K_CHECK: begin
                        state_reg   <= S_RD_WAIT;
                        oe_reg      <= 1'b1;
                        addr_reg    <= vec_addr;
                        exp_reg     <= vec_data;
                        aux_cnt_reg <= '0;
                     end
                     K_END: begin
                        state_reg     <= S_REPORT;
                        res_valid_reg <= 1'b1;
                     end
                     default: begin
                        state_reg     <= S_DRAIN;
                        vec_ready_reg <= 1'b1;
                        status_reg    <= ST_PROTO;
                     end
                  endcase
               end
            end
            S_RD_WAIT: begin
               aux_cnt_reg <= aux_cnt_reg + 1'b1;
               if (Sout_DataRdy) begin
                  state_reg     <= S_CHK;
                  vec_ready_reg <= 1'b1;
                  checked_reg   <= checked_reg + 16'd1;
                  if (!rd_match) begin
                     status_reg <= merge_status(status_reg, ST_FAIL);
                  end
               end else if (aux_cnt_reg == ACC_LAST) begin
                  state_reg     <= S_DRAIN;
                  vec_ready_reg <= 1'b1;
                  status_reg    <= merge_status(status_reg, ST_FAIL);
               end
            end
            S_DRAIN: begin
               if (accept && kind == K_END) begin
                  state_reg     <= S_REPORT;
                  vec_ready_reg <= 1'b0;
                  res_valid_reg <= 1'b1;
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  res_valid_reg <= 1'b0;
                  run_idx_reg   <= run_idx_reg + 16'd1;
                  status_reg    <= ST_PASS;
                  cyc_reg       <= '0;
                  checked_reg   <= '0;
                  aux_cnt_reg   <= '0;
                  if (vec_valid) begin
                     state_reg       <= S_DRST;
                     dut_reset_n_reg <= 1'b0;
                  end else begin
                     state_reg <= S_IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg     <= S_IDLE;
               vec_ready_reg <= 1'b0;
               res_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign vec_ready       = vec_ready_reg;
   assign dut_reset_n     = dut_reset_n_reg;
   assign dut_start_port  = start_reg;
   assign S_oe_ram        = oe_reg;
   assign S_we_ram        = we_reg;
   assign S_addr_ram      = addr_reg;
   assign S_Wdata_ram     = wdata_reg;
   assign S_data_ram_size = 6'(DATA_W);
   assign res_valid       = res_valid_reg;
   assign res_status      = status_reg;
   assign res_cycles      = cyc_reg;
   assign res_run_idx     = run_idx_reg;
   assign res_checked     = checked_reg;
   assign busy            = busy_reg;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer with a behavioural slave RAM and a
// programmable-latency accelerator model; one line printed per run record.
module tb_hls_run_sequencer;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int CYC_W  = 32;
   localparam logic [1:0] KW = 2'd0;
   localparam logic [1:0] KS = 2'd1;
   localparam logic [1:0] KC = 2'd2;
   localparam logic [1:0] KE = 2'd3;

   logic              clock;
   logic              reset;
   logic              vec_valid;
   logic              vec_ready;
   logic [1:0]        vec_kind;
   logic [ADDR_W-1:0] vec_addr;
   logic [DATA_W-1:0] vec_data;
   logic              dut_reset_n;
   logic              dut_start_port;
   logic              dut_done_port;
   logic              S_oe_ram;
   logic              S_we_ram;
   logic [ADDR_W-1:0] S_addr_ram;
   logic [DATA_W-1:0] S_Wdata_ram;
   logic [5:0]        S_data_ram_size;
   logic [DATA_W-1:0] Sout_Rdata_ram;
   logic              Sout_DataRdy;
   logic              res_valid;
   logic              res_ready;
   logic [1:0]        res_status;
   logic [CYC_W-1:0]  res_cycles;
   logic [15:0]       res_run_idx;
   logic [15:0]       res_checked;
   logic              busy;

   int checks = 0;
   int errors = 0;

   hls_run_sequencer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .CYC_W      (CYC_W),
      .TIMEOUT    (50),
      .RST_CYCLES (2),
      .MAX_ULP    (1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .vec_valid       (vec_valid),
      .vec_ready       (vec_ready),
      .vec_kind        (vec_kind),
      .vec_addr        (vec_addr),
      .vec_data        (vec_data),
      .dut_reset_n     (dut_reset_n),
      .dut_start_port  (dut_start_port),
      .dut_done_port   (dut_done_port),
      .S_oe_ram        (S_oe_ram),
      .S_we_ram        (S_we_ram),
      .S_addr_ram      (S_addr_ram),
      .S_Wdata_ram     (S_Wdata_ram),
      .S_data_ram_size (S_data_ram_size),
      .Sout_Rdata_ram  (Sout_Rdata_ram),
      .Sout_DataRdy    (Sout_DataRdy),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_status      (res_status),
      .res_cycles      (res_cycles),
      .res_run_idx     (res_run_idx),
      .res_checked     (res_checked),
      .busy            (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Slave RAM: two-cycle response after each strobe unless muted.
   logic [DATA_W-1:0] mem [0:255];
   logic [DATA_W-1:0] rdata_q = '0;
   int  rcnt = 0;
   bit  slave_mute = 1'b0;
   always @(posedge clock) begin
      if (S_we_ram) mem[S_addr_ram[7:0]] <= S_Wdata_ram;
      if (S_oe_ram) rdata_q <= mem[S_addr_ram[7:0]];
      if ((S_we_ram || S_oe_ram) && !slave_mute) rcnt <= 2;
      else if (rcnt > 0) rcnt <= rcnt - 1;
   end
   assign Sout_DataRdy   = (rcnt == 1);
   assign Sout_Rdata_ram = rdata_q;

   // Accelerator: done asserted done_delay cycles after start (0 = never).
   int done_delay = 0;
   int dcnt = 0;
   always @(posedge clock) begin
      if (reset) dcnt <= 0;
      else if (dut_start_port && done_delay > 0) dcnt <= done_delay;
      else if (dcnt > 0) dcnt <= dcnt - 1;
   end
   assign dut_done_port = (dcnt == 1);

   int low_run = 0;
   int last_low = 0;
   int start_cnt = 0;
   int start_mark = 0;
   int overlap = 0;
   always @(negedge clock) begin
      if (!dut_reset_n) low_run <= low_run + 1;
      else begin
         if (low_run > 0) last_low <= low_run;
         low_run <= 0;
      end
      if (dut_start_port) start_cnt <= start_cnt + 1;
      if (S_we_ram && S_oe_ram) overlap <= overlap + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [1:0] k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n = 0;
      vec_valid = 1'b1;
      vec_kind  = k;
      vec_addr  = a;
      vec_data  = d;
      while (!vec_ready && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("vec_accept", {63'd0, vec_ready}, 64'd1);
      @(negedge clock);
      vec_valid = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic [1:0] st, input int cyc, input int chk,
                             input int idx, input int starts, input bit chain, input int hold);
      int n = 0;
      while (!res_valid && n < 300) begin
         @(negedge clock);
         n++;
      end
      $display("run %0d: status=%0d cycles=%0d checked=%0d", res_run_idx, res_status, res_cycles, res_checked);
      check({tag, "_valid"},   {63'd0, res_valid}, 64'd1);
      check({tag, "_status"},  {62'd0, res_status}, {62'd0, st});
      check({tag, "_cycles"},  {32'd0, res_cycles}, 64'(cyc));
      check({tag, "_checked"}, {48'd0, res_checked}, 64'(chk));
      check({tag, "_run_idx"}, {48'd0, res_run_idx}, 64'(idx));
      check({tag, "_rst_low"}, 64'(last_low), 64'd2);
      check({tag, "_starts"},  64'(start_cnt - start_mark), 64'(starts));
      if (chain) begin
         vec_valid = 1'b1;
         vec_kind  = KS;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check({tag, "_hold_valid"},  {63'd0, res_valid}, 64'd1);
         check({tag, "_hold_ready"},  {63'd0, vec_ready}, 64'd0);
         check({tag, "_hold_cycles"}, {32'd0, res_cycles}, 64'(cyc));
      end
      res_ready = 1'b1;
      @(negedge clock);
      res_ready = 1'b0;
      check({tag, "_released"}, {63'd0, res_valid}, 64'd0);
      start_mark = start_cnt;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},    {63'd0, busy}, 64'd0);
      check({tag, "_ready"},   {63'd0, vec_ready}, 64'd0);
      check({tag, "_dut_rn"},  {63'd0, dut_reset_n}, 64'd0);
      check({tag, "_start"},   {63'd0, dut_start_port}, 64'd0);
      check({tag, "_we_oe"},   {62'd0, S_we_ram, S_oe_ram}, 64'd0);
      check({tag, "_res_val"}, {63'd0, res_valid}, 64'd0);
      check({tag, "_run_idx"}, {48'd0, res_run_idx}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      vec_valid = 1'b0;
      vec_kind = '0;
      vec_addr = '0;
      vec_data = '0;
      res_ready = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      check("ram_size", {58'd0, S_data_ram_size}, 64'd32);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("idle_dut_rn", {63'd0, dut_reset_n}, 64'd1);
      check("idle_busy", {63'd0, busy}, 64'd0);
      start_mark = start_cnt;

      // PASS: three preloads, done 10 cycles after start, two matching checks
      done_delay = 10;
      send(KW, 14'h10, 32'h0000_000A);
      send(KW, 14'h11, 32'h0000_000B);
      send(KW, 14'h12, 32'h0000_000C);
      send(KS, '0, '0);
      send(KC, 14'h10, 32'h0000_000A);
      send(KC, 14'h12, 32'h0000_000C);
      send(KE, '0, '0);
      get_result("pass", 2'd0, 11, 2, 0, 1, 1'b0, 0);

      // FAIL: read-back 6 against expected 5, done on the cycle after start
      done_delay = 1;
      send(KW, 14'h20, 32'h0000_0006);
      send(KS, '0, '0);
      send(KC, 14'h20, 32'h0000_0005);
      send(KE, '0, '0);
      get_result("fail", 2'd1, 2, 1, 1, 1, 1'b0, 0);

      // TIMEOUT: done never arrives, trailing checks drained
      done_delay = 0;
      send(KW, 14'h30, 32'h0000_0001);
      send(KS, '0, '0);
      send(KC, 14'h30, 32'h0000_0001);
      send(KC, 14'h10, 32'h0000_000A);
      send(KE, '0, '0);
      get_result("timeout", 2'd2, 50, 0, 2, 1, 1'b0, 0);

      // PROTO: check before start, remaining entries drained
      send(KC, 14'h10, 32'h0000_000A);
      send(KW, 14'h40, 32'h0000_0007);
      send(KE, '0, '0);
      get_result("proto", 2'd3, 0, 0, 3, 0, 1'b0, 0);

      // Back-to-back runs; the middle record is held for 20 cycles
      done_delay = 3;
      send(KS, '0, '0);
      send(KE, '0, '0);
      get_result("b2b0", 2'd0, 4, 0, 4, 1, 1'b1, 0);
      done_delay = 2;
      send(KS, '0, '0);
      send(KE, '0, '0);
      get_result("b2b1", 2'd0, 3, 0, 5, 1, 1'b1, 20);
      done_delay = 5;
      send(KS, '0, '0);
      send(KE, '0, '0);
      get_result("b2b2", 2'd0, 6, 0, 6, 1, 1'b0, 0);

      // Reset while waiting for done
      done_delay = 0;
      send(KS, '0, '0);
      repeat (5) @(negedge clock);
      check("wait_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(negedge clock);
      check_reset_outputs("midrun");
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("post_rst_dut_rn", {63'd0, dut_reset_n}, 64'd1);
      start_mark = start_cnt;

      done_delay = 1;
      send(KW, 14'h50, 32'h1234_5678);
      send(KS, '0, '0);
      send(KC, 14'h50, 32'h1234_5678);
      send(KE, '0, '0);
      get_result("after_rst", 2'd0, 2, 1, 0, 1, 1'b0, 0);

      // Slave never answers a write: FAIL after the access timeout, run continues
      slave_mute = 1'b1;
      send(KW, 14'h60, 32'h0000_0001);
      @(negedge clock);
      slave_mute = 1'b0;
      send(KS, '0, '0);
      send(KE, '0, '0);
      get_result("wr_timeout", 2'd1, 2, 0, 1, 1, 1'b0, 0);

`ifdef HLS_RUNSEQ_ULP_EN
      send(KW, 14'h70, 32'h3F80_0001);
      send(KS, '0, '0);
      send(KC, 14'h70, 32'h3F80_0000);
      send(KE, '0, '0);
      get_result("ulp", 2'd0, 2, 1, 2, 1, 1'b0, 0);
`endif

      check("strobe_overlap", 64'(overlap), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
